// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: synchronizes raw SPI pins into clk, assembles 16-bit frames and
// commits validated writes into a five-entry control register bank.
module spi_reg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  localparam logic [4:0] FrameBits = 5'd16;
  localparam logic [4:0] CntSat    = 5'd17;
  localparam logic [6:0] LastAddr  = 7'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        commit_ok, commit_bad, wr_en;

  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic       done_q, err_q;

  // ncs chain resets high so releasing reset never looks like a chip-select fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ncs_fall) state_d = StShift;
      StShift:  if (ncs_rise) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // A clock edge coinciding with chip-select release is not part of the frame
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (sclk_rise && !ncs_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != CntSat) cnt_d = cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    commit_ok  = (state_q == StCommit) && (cnt_q == FrameBits);
    commit_bad = (state_q == StCommit) && (cnt_q != FrameBits);
    wr_en      = commit_ok && shift_q[15] && (shift_q[14:8] <= LastAddr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= commit_ok;
      err_q  <= commit_bad;
      if (wr_en) begin
        case (shift_q[10:8])
          3'd0:    out_lo_q <= shift_q[7:0];
          3'd1:    out_hi_q <= shift_q[7:0];
          3'd2:    pwm_lo_q <= shift_q[7:0];
          3'd3:    pwm_hi_q <= shift_q[7:0];
          3'd4:    duty_q   <= shift_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign frame_done      = done_q;
  assign frame_err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed and random SPI frames checked cycle by cycle against a
// frame-level model of the register bank and commit pulses.
module tb_spi_reg_ctrl;

  localparam int Sync = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ncs = 1'b1;
  logic       copi = 1'b0;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       frame_done, frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(Sync)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .ncs             (ncs),
    .copi            (copi),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         ok;
    bit         wr;
    int         addr;
    logic [7:0] data;
  } commit_t;

  commit_t    pend[$];
  logic [7:0] mreg [5];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic exp_done, exp_err;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_done = pend[0].ok;
      exp_err  = !pend[0].ok;
      if (pend[0].wr) mreg[pend[0].addr] = pend[0].data;
      void'(pend.pop_front());
    end
    check("reg00", r0, mreg[0]);
    check("reg01", r1, mreg[1]);
    check("reg02", r2, mreg[2]);
    check("reg03", r3, mreg[3]);
    check("reg04", r4, mreg[4]);
    check("frame_done", {7'd0, frame_done}, {7'd0, exp_done});
    check("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
  endtask

  // Shifts bits w[nbits-1:0] MSB first; sclk left low afterwards
  task automatic send_bits(input logic [31:0] w, input int nbits, input int ph);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = w[i];
      sclk = 1'b0;
      tick(ph);
      sclk = 1'b1;
      tick(ph);
    end
    sclk = 1'b0;
    tick(ph);
  endtask

  // Whole frame; the last 16 bits shifted decide the outcome when exactly 16 were sent
  task automatic frame(input logic [31:0] w, input int nbits, input int ph, input int gap,
                       input bit idle_clk);
    commit_t    c;
    logic [15:0] word;
    ncs = 1'b0;
    tick(ph);
    send_bits(w, nbits, ph);
    ncs = 1'b1;
    word   = w[15:0];
    c.due  = cyc + Sync + 2;
    c.ok   = (nbits == 16);
    c.wr   = c.ok && word[15] && (word[14:8] <= 7'd4);
    c.addr = int'(word[10:8]);
    c.data = word[7:0];
    pend.push_back(c);
    if (idle_clk) begin
      tick(1);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
      tick(3);
    end
    tick(gap);
  endtask

  initial begin
    int d0, e0;
    model_reset();
    tick(3);
    check("reset_r0", r0, 8'h00);
    check("reset_pulse", {6'd0, frame_done, frame_err}, 8'h00);
    rst_n = 1'b1;
    tick(20);

    // Writes to 0x00 and 0x04
    d0 = done_cnt;
    frame(32'h80F0, 16, 3, 6, 1'b0);
    frame(32'h847F, 16, 4, 6, 1'b0);
    check("wr_model_r0", mreg[0], 8'hF0);
    check("wr_r0", r0, 8'hF0);
    check("wr_r4", r4, 8'h7F);
    check("wr_done_cnt", 8'(done_cnt - d0), 8'd2);

    // Read and out-of-range write leave registers unchanged
    d0 = done_cnt; e0 = err_cnt;
    frame(32'h0155, 16, 3, 6, 1'b1);
    frame(32'h85AA, 16, 3, 6, 1'b0);
    check("rd_r1", r1, 8'h00);
    check("rd_done_cnt", 8'(done_cnt - d0), 8'd2);
    check("rd_err_cnt", 8'(err_cnt - e0), 8'd0);

    // Short and long frames are rejected
    d0 = done_cnt; e0 = err_cnt;
    frame(32'h833C >> 1, 15, 3, 6, 1'b0);
    frame({15'd0, 16'h833C, 1'b1}, 17, 3, 6, 1'b0);
    check("len_r3", r3, 8'h00);
    check("len_err_cnt", 8'(err_cnt - e0), 8'd2);
    check("len_done_cnt", 8'(done_cnt - d0), 8'd0);

    // Reset in the middle of a frame discards it
    d0 = done_cnt; e0 = err_cnt;
    ncs = 1'b0;
    tick(3);
    send_bits(32'h82, 8, 3);
    rst_n = 1'b0;
    model_reset();
    tick(2);
    ncs = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("mid_pulses", 8'((done_cnt - d0) + (err_cnt - e0)), 8'd0);
    check("mid_r0", r0, 8'h00);
    frame(32'h8201, 16, 3, 6, 1'b0);
    check("mid_r2", r2, 8'h01);

    // Back-to-back with minimum chip-select gap
    d0 = done_cnt;
    frame(32'h8111, 16, 3, Sync + 2, 1'b0);
    frame(32'h8222, 16, 3, 8, 1'b0);
    check("b2b_r1", r1, 8'h11);
    check("b2b_r2", r2, 8'h22);
    check("b2b_done_cnt", 8'(done_cnt - d0), 8'd2);

    // Random frames
    for (int n = 0; n < 40; n++) begin
      logic [15:0] word;
      logic [31:0] w;
      int nb;
      word[15]   = 1'($urandom_range(0, 3) != 0);
      word[14:8] = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 5)) : 7'($urandom);
      word[7:0]  = 8'($urandom);
      case ($urandom_range(0, 11))
        0:       nb = 15;
        1:       nb = 17;
        2:       nb = 18;
        3:       nb = 0;
        4:       nb = 14;
        default: nb = 16;
      endcase
      if (nb >= 16) w = ({16'd0, word} << (nb - 16)) | 32'($urandom_range(0, 3));
      else w = {16'd0, word} >> (16 - nb);
      frame(w, nb, $urandom_range(3, 5), $urandom_range(Sync + 2, 8), 1'($urandom_range(0, 1)));
    end
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
